// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register and operand-select stage feeding
// the ALU. Captures decoded operands and control from ID, resolves RAW hazards
// by forwarding from EX/MEM and MEM/WB, and inserts bubbles on load-use.
//
// Build option EX_FORWARD_EN:
//   defined   - EX/MEM and MEM/WB results are forwarded onto ex_a/ex_b; only a
//               load-use pair stalls.
//   undefined - ex_a/ex_b are the stored values; hazard_stall interlocks on
//               any RAW against EX, EX/MEM or MEM/WB (register file is
//               write-before-read, so nothing beyond MEM/WB is needed).
module ex_operand_stage #(
   parameter int WIDTH = 16,
   parameter int RA_W  = 4,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [OP_W-1:0]  id_opcode,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic [RA_W-1:0]  id_rd,
   input  logic [WIDTH-1:0] id_rs_val,
   input  logic [WIDTH-1:0] id_rt_val,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_use_imm,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             exmem_regwrite,
   input  logic [RA_W-1:0]  exmem_rd,
   input  logic [WIDTH-1:0] exmem_result,
   input  logic             memwb_regwrite,
   input  logic [RA_W-1:0]  memwb_rd,
   input  logic [WIDTH-1:0] memwb_result,
   output logic             ex_valid,
   output logic [OP_W-1:0]  ex_opcode,
   output logic [RA_W-1:0]  ex_rd,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic [WIDTH-1:0] ex_a,
   output logic [WIDTH-1:0] ex_b,
   output logic             hazard_stall
);

   logic             valid_q,    valid_d;
   logic [OP_W-1:0]  opcode_q,   opcode_d;
   logic [RA_W-1:0]  rs_q,       rs_d;
   logic [RA_W-1:0]  rt_q,       rt_d;
   logic [RA_W-1:0]  rd_q,       rd_d;
   logic [WIDTH-1:0] a_q,        a_d;
   logic [WIDTH-1:0] b_q,        b_d;
   logic             regwrite_q, regwrite_d;
   logic             memread_q,  memread_d;

   logic             load_use;

   // True when a writing destination matches one of the ID sources that is
   // actually read (rt is ignored for immediate forms). R0 never conflicts.
   function automatic logic raw_hit(input logic            we,
                                    input logic [RA_W-1:0] dst,
                                    input logic [RA_W-1:0] rs,
                                    input logic [RA_W-1:0] rt,
                                    input logic            use_imm);
      raw_hit = we && (dst != '0) && ((dst == rs) || (!use_imm && (dst == rt)));
   endfunction

   // Operand forward mux: EX/MEM is newer than MEM/WB so it wins; R0 and
   // unmatched sources keep the captured value.
   function automatic logic [WIDTH-1:0] fwd(input logic [RA_W-1:0]  src,
                                            input logic [WIDTH-1:0] stored,
                                            input logic             em_we,
                                            input logic [RA_W-1:0]  em_rd,
                                            input logic [WIDTH-1:0] em_res,
                                            input logic             mw_we,
                                            input logic [RA_W-1:0]  mw_rd,
                                            input logic [WIDTH-1:0] mw_res);
      if (src == '0)                       fwd = stored;
      else if (em_we && (em_rd == src))    fwd = em_res;
      else if (mw_we && (mw_rd == src))    fwd = mw_res;
      else                                 fwd = stored;
   endfunction

   // Hazard detection: load-use always; full RAW interlock without forwarding
   always_comb begin
      load_use = id_valid && valid_q && memread_q &&
                 raw_hit(1'b1, rd_q, id_rs, id_rt, id_use_imm);
`ifdef EX_FORWARD_EN
      hazard_stall = load_use;
`else
      hazard_stall = load_use ||
                     (id_valid && (raw_hit(valid_q && regwrite_q, rd_q, id_rs, id_rt, id_use_imm) ||
                                   raw_hit(exmem_regwrite, exmem_rd, id_rs, id_rt, id_use_imm) ||
                                   raw_hit(memwb_regwrite, memwb_rd, id_rs, id_rt, id_use_imm)));
`endif
   end

   // Next-state for the ID/EX register: flush > stall > hazard bubble > load
   always_comb begin
      valid_d    = valid_q;
      opcode_d   = opcode_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      a_d        = a_q;
      b_d        = b_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      if (flush || (!stall && hazard_stall)) begin
         valid_d    = 1'b0;
         opcode_d   = '0;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         a_d        = '0;
         b_d        = '0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
      end else if (!stall) begin
         valid_d    = id_valid;
         opcode_d   = id_opcode;
         rs_d       = id_rs;
         // Immediate forms park rt at R0 so the immediate is never overridden
         rt_d       = id_use_imm ? '0 : id_rt;
         rd_d       = id_rd;
         a_d        = id_rs_val;
         b_d        = id_use_imm ? id_imm : id_rt_val;
         regwrite_d = id_regwrite;
         memread_d  = id_memread;
      end
   end

   // ID/EX register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         opcode_q   <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         opcode_q   <= opcode_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         a_q        <= a_d;
         b_q        <= b_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
      end
   end

   // Output drive: control gated by valid; operands forwarded every cycle,
   // including while stalled, so held operands track downstream results
   always_comb begin
      ex_valid    = valid_q;
      ex_opcode   = opcode_q;
      ex_rd       = rd_q;
      ex_regwrite = regwrite_q && valid_q;
      ex_memread  = memread_q && valid_q;
`ifdef EX_FORWARD_EN
      ex_a = fwd(rs_q, a_q, exmem_regwrite, exmem_rd, exmem_result,
                 memwb_regwrite, memwb_rd, memwb_result);
      ex_b = fwd(rt_q, b_q, exmem_regwrite, exmem_rd, exmem_result,
                 memwb_regwrite, memwb_rd, memwb_result);
`else
      ex_a = a_q;
      ex_b = b_q;
`endif
   end

endmodule
